// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO registers.
// Runs multi-cycle mult/div, handles mthi/mtlo/mfhi/mflo, and raises
// the D-stage stall request for MD-class instructions.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDInstr,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned DW         = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DW-1:0]     hi_tmp, lo_tmp, hi_tmp_nxt, lo_tmp_nxt;
  logic [DW-1:0]     hi_nxt, lo_nxt;

  logic [2*DW-1:0]   mul_s, mul_u;
  logic              div_zero;
  logic [DW-1:0]     divisor_u, quo_u, rem_u;
  logic [DW-1:0]     abs_a, abs_b, quo_m, rem_m, quo_s, rem_s;
  logic [DW-1:0]     res_hi, res_lo;

  // Arithmetic result for the op presented in E; divide by zero keeps HI/LO.
  always_comb begin
    mul_s     = {{DW{E_A[DW-1]}}, E_A} * {{DW{E_B[DW-1]}}, E_B};
    mul_u     = {{DW{1'b0}}, E_A} * {{DW{1'b0}}, E_B};
    div_zero  = (E_B == '0);
    divisor_u = div_zero ? DW'(1) : E_B;
    quo_u     = E_A / divisor_u;
    rem_u     = E_A % divisor_u;
    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    abs_a     = E_A[DW-1] ? (DW'(0) - E_A) : E_A;
    abs_b     = E_B[DW-1] ? (DW'(0) - E_B) : divisor_u;
    quo_m     = abs_a / abs_b;
    rem_m     = abs_a % abs_b;
    quo_s     = (E_A[DW-1] ^ E_B[DW-1]) ? (DW'(0) - quo_m) : quo_m;
    rem_s     = E_A[DW-1] ? (DW'(0) - rem_m) : rem_m;
    res_hi    = HI;
    res_lo    = LO;
    case (E_MDOp)
      OP_MULT: begin
        res_hi = mul_s[2*DW-1:DW];
        res_lo = mul_s[DW-1:0];
      end
      OP_MULTU: begin
        res_hi = mul_u[2*DW-1:DW];
        res_lo = mul_u[DW-1:0];
      end
      OP_DIV: begin
        if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  // State register: FSM state, countdown, pending result and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_tmp <= hi_tmp_nxt;
      lo_tmp <= lo_tmp_nxt;
      HI     <= hi_nxt;
      LO     <= lo_nxt;
    end
  end

  // Next-state: start/latch in idle, count down and write back when busy.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_tmp_nxt = hi_tmp;
    lo_tmp_nxt = lo_tmp;
    hi_nxt     = HI;
    lo_nxt     = LO;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_BUSY;
          cnt_nxt    = (E_MDOp == OP_MULT || E_MDOp == OP_MULTU) ?
                       CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          hi_tmp_nxt = res_hi;
          lo_tmp_nxt = res_lo;
        end else if (E_MDOp == OP_MTHI) begin
          hi_nxt = E_A;
        end else if (E_MDOp == OP_MTLO) begin
          lo_nxt = E_A;
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_IDLE;
          hi_nxt    = hi_tmp;
          lo_nxt    = lo_tmp;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: start/stall handshake and mfhi/mflo read mux.
  always_comb begin
    busy     = (state == S_BUSY);
    start    = (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU) && !busy;
    md_stall = D_MDInstr && (start || busy);
    E_MDOut  = '0;
    if (E_MDOp == OP_MFHI) begin
      E_MDOut = HI;
    end else if (E_MDOp == OP_MFLO) begin
      E_MDOut = LO;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        D_MDInstr;
  logic        start, busy, md_stall;
  logic [31:0] E_MDOut, HI, LO;

  int n_pass  = 0;
  int n_total = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_MDInstr (D_MDInstr),
    .start     (start),
    .busy      (busy),
    .md_stall  (md_stall),
    .E_MDOut   (E_MDOut),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue op in this cycle, optionally drive busy_op during busy, check window and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] busy_op, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n_busy;
    n_busy = 0;
    E_MDOp = op; E_A = a; E_B = b;
    #1;
    check({tag, "_start"}, 32'(start), 32'd1);
    step();
    E_MDOp = busy_op; E_A = 32'hDEAD_BEEF; E_B = 32'h1;
    while (busy && n_busy < 100) begin
      n_busy++;
      step();
    end
    E_MDOp = 4'd0;
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(n));
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b0; E_MDOp = 4'd0; E_A = '0; E_B = '0; D_MDInstr = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", 32'(start), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Bubble and undefined opcodes never start and read 0.
    E_MDOp = 4'd9; #1;
    check("op9_start", 32'(start), 32'd0);
    check("op9_out", E_MDOut, 32'd0);
    E_MDOp = 4'd0; #1;
    check("op0_start", 32'(start), 32'd0);

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 4'd0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 4'd0, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 4'd0, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 10, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(4'd4, 32'd100, 32'd7, 4'd0, 10, 32'd2, 32'd14, "divu");
    run_op(4'd1, 32'd3, 32'd4, 4'd5, 5, 32'd0, 32'd12, "mult_ign_mthi");
    run_op(4'd1, 32'd5, 32'd6, 4'd1, 5, 32'd0, 32'd30, "mult_ign_mult");

    // mthi/mtlo write at the edge, read back next cycle.
    E_MDOp = 4'd5; E_A = 32'hAA; #1;
    check("mthi_same_cycle_out", E_MDOut, 32'd0);
    step();
    E_MDOp = 4'd7; #1;
    check("mfhi_aa", E_MDOut, 32'hAA);
    E_MDOp = 4'd5; E_A = 32'h55;
    step();
    E_MDOp = 4'd6; E_A = 32'h55;
    step();
    E_MDOp = 4'd7; #1;
    check("mfhi_55", E_MDOut, 32'h55);
    E_MDOp = 4'd8; #1;
    check("mflo_55", E_MDOut, 32'h55);
    E_MDOp = 4'd0;

    run_op(4'd4, 32'h1234, 32'd0, 4'd0, 10, 32'h55, 32'h55, "divu_by0");

    // mult with mflo waiting in D: stall through t0..t0+5, release at t0+6.
    E_MDOp = 4'd1; E_A = 32'd7; E_B = 32'hFFFF_FFFD; D_MDInstr = 1'b1; #1;
    check("stall_t0", 32'(md_stall), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      E_MDOp = 4'd0; #1;
      check($sformatf("stall_t%0d", i), 32'(md_stall), 32'd1);
    end
    step();
    check("stall_release", 32'(md_stall), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
    step();
    E_MDOp = 4'd8; D_MDInstr = 1'b0; #1;
    check("mflo_after_mult", E_MDOut, 32'hFFFF_FFEB);
    E_MDOp = 4'd7; #1;
    check("mfhi_after_mult", E_MDOut, 32'hFFFF_FFFF);

    // Non-MD D instr never stalls; then abort a div by reset at busy cycle 3.
    E_MDOp = 4'd3; E_A = 32'd10; E_B = 32'd3; D_MDInstr = 1'b0; #1;
    check("nomd_stall_start", 32'(md_stall), 32'd0);
    step();
    E_MDOp = 4'd0; #1;
    check("nomd_stall_busy", 32'(md_stall), 32'd0);
    D_MDInstr = 1'b1; #1;
    check("md_stall_busy", 32'(md_stall), 32'd1);
    D_MDInstr = 1'b0;
    step(); step();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
